// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: opcode constants, FSM encoding and operand-use decode
// shared by the hazard controller.
package pipeline_hazard_ctrl_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_HOLD       = 2'd1;
    localparam logic [1:0] ST_FLUSH_PEND = 2'd2;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP_OP || op == OP_STORE || op == OP_BRANCH;
    endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: saturating event counter; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / branch / memory-wait hazard control for a
// 5-stage pipeline, with stall and flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state_o
);
    logic [1:0] state, state_nxt;
    logic load_use, fp, flush_now, load_stall, imem_stall, stall_inc;

    assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                      ((uses_rs1(id_opcode) && ex_rd == id_rs1) ||
                       (uses_rs2(id_opcode) && ex_rd == id_rs2));

    // HOLD with memory released behaves exactly like RUN; only a latched
    // branch (FLUSH_PEND) forces the flush once memory frees up.
    always_comb begin
        fp         = state == ST_FLUSH_PEND;
        flush_now  = !dmem_busy && (fp || ex_branch_taken);
        load_stall = !dmem_busy && !fp && !ex_branch_taken && load_use;
        imem_stall = !dmem_busy && !fp && !ex_branch_taken && !load_use && !imem_ready;
        stall_inc  = !rst && (dmem_busy || load_stall || imem_stall);
        state_nxt  = state == 2'd3 ? ST_RUN :
                     !dmem_busy ? ST_RUN :
                     (fp || ex_branch_taken) ? ST_FLUSH_PEND : ST_HOLD;
        pc_write     = !rst && !dmem_busy && !load_stall && !imem_stall;
        if_id_enable = !rst && !dmem_busy && !load_stall;
        if_id_flush  = rst || flush_now || imem_stall;
        id_ex_bubble = rst || flush_now || load_stall;
        pipe_hold    = !rst && dmem_busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    assign state_o = state;

    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .rst(rst), .inc(stall_inc), .clr(cnt_clear), .count(stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush (
        .clk(clk), .rst(rst), .inc(!rst && flush_now), .clr(cnt_clear), .count(flush_count)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios with hand-computed expectations.
// ctl vector order: {pc_write, if_id_enable, if_id_flush, id_ex_bubble, pipe_hold}.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam logic [4:0] C_NORM  = 5'b11000;
    localparam logic [4:0] C_LOAD  = 5'b00010;
    localparam logic [4:0] C_IMEM  = 5'b01100;
    localparam logic [4:0] C_FLUSH = 5'b11110;
    localparam logic [4:0] C_HOLD  = 5'b00001;
    localparam logic [4:0] C_RST   = 5'b00110;

    logic clk = 0, rst = 1;
    logic [6:0] id_opcode = 7'b0110011;
    logic [4:0] id_rs1 = 5'd6, id_rs2 = 5'd7, ex_rd = 5'd0;
    logic ex_mem_read = 0, ex_branch_taken = 0, imem_ready = 1, dmem_busy = 0, cnt_clear = 0;
    logic pc_write, if_id_enable, if_id_flush, id_ex_bubble, pipe_hold;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [1:0] state_o;
    logic [4:0] ctl;
    int checks = 0, errors = 0;

    assign ctl = {pc_write, if_id_enable, if_id_flush, id_ex_bubble, pipe_hold};

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .imem_ready(imem_ready), .dmem_busy(dmem_busy), .cnt_clear(cnt_clear),
        .pc_write(pc_write), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters;
        cnt_clear = 1;
        cyc();
        cnt_clear = 0;
        checks++;
        if (stall_cycles !== 0 || flush_count !== 0) begin
            errors++;
            $display("FAIL clear got stall=%0d flush=%0d want 0/0", stall_cycles, flush_count);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (ctl !== C_RST || state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_out got ctl=%b st=%0d want %b st=0", ctl, state_o, C_RST);
        end
        cyc();
        checks++;
        if (stall_cycles !== 0 || flush_count !== 0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        rst = 0;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            errors++;
            $display("FAIL normal got %b want %b", ctl, C_NORM);
        end
        cyc();
    endtask

    task automatic test_load_use;
        ex_mem_read = 1; ex_rd = 5'd6;
        #2;
        checks++;
        if (ctl !== C_LOAD) begin
            errors++;
            $display("FAIL load_use_rs1 got %b want %b", ctl, C_LOAD);
        end
        cyc();
        ex_mem_read = 0;
        #2;
        checks++;
        if (ctl !== C_NORM || stall_cycles !== 1) begin
            errors++;
            $display("FAIL load_use_after got %b stall=%0d want %b stall=1", ctl, stall_cycles, C_NORM);
        end
        ex_mem_read = 1; ex_rd = 5'd7;
        #2;
        checks++;
        if (ctl !== C_LOAD) begin
            errors++;
            $display("FAIL load_use_rs2 got %b want %b", ctl, C_LOAD);
        end
        cyc();
        ex_mem_read = 0;
        #2;
        checks++;
        if (stall_cycles !== 2) begin
            errors++;
            $display("FAIL load_use_cnt got %0d want 2", stall_cycles);
        end
    endtask

    task automatic test_no_stall;
        id_opcode = 7'b0110111; id_rs1 = 5'd6; ex_mem_read = 1; ex_rd = 5'd6;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            errors++;
            $display("FAIL lui_rs1 got %b want %b", ctl, C_NORM);
        end
        cyc();
        id_opcode = 7'b0110011; id_rs1 = 5'd0; ex_rd = 5'd0;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            errors++;
            $display("FAIL rd_zero got %b want %b", ctl, C_NORM);
        end
        id_opcode = 7'b0010011; id_rs1 = 5'd1; id_rs2 = 5'd9; ex_rd = 5'd9;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            errors++;
            $display("FAIL itype_rs2 got %b want %b", ctl, C_NORM);
        end
        cyc();
        checks++;
        if (stall_cycles !== 2) begin
            errors++;
            $display("FAIL no_stall_cnt got %0d want 2", stall_cycles);
        end
        ex_mem_read = 0; id_opcode = 7'b0110011; id_rs1 = 5'd6; id_rs2 = 5'd7; ex_rd = 5'd0;
    endtask

    task automatic test_branch_load;
        clear_counters();
        ex_mem_read = 1; ex_rd = 5'd6; ex_branch_taken = 1;
        #2;
        checks++;
        if (ctl !== C_FLUSH) begin
            errors++;
            $display("FAIL branch_load got %b want %b", ctl, C_FLUSH);
        end
        cyc();
        ex_mem_read = 0; ex_branch_taken = 0; ex_rd = 5'd0;
        checks++;
        if (flush_count !== 1 || stall_cycles !== 0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL branch_cnt got f=%0d s=%0d st=%0d want 1/0/0", flush_count, stall_cycles, state_o);
        end
    endtask

    task automatic test_dmem_branch;
        clear_counters();
        dmem_busy = 1; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (ctl !== C_HOLD) begin
                errors++;
                $display("FAIL dmem_hold%0d got %b want %b", i, ctl, C_HOLD);
            end
            cyc();
            ex_branch_taken = 0;
            checks++;
            if (state_o !== 2'd2) begin
                errors++;
                $display("FAIL dmem_state%0d got %0d want 2", i, state_o);
            end
        end
        dmem_busy = 0;
        #2;
        checks++;
        if (ctl !== C_FLUSH) begin
            errors++;
            $display("FAIL pend_flush got %b want %b", ctl, C_FLUSH);
        end
        cyc();
        #2;
        checks++;
        if (ctl !== C_NORM || state_o !== 2'd0 || flush_count !== 1 || stall_cycles !== 3) begin
            errors++;
            $display("FAIL pend_after got %b st=%0d f=%0d s=%0d want %b 0/1/3",
                     ctl, state_o, flush_count, stall_cycles, C_NORM);
        end
    endtask

    task automatic test_hold_return;
        dmem_busy = 1;
        cyc();
        dmem_busy = 0;
        #2;
        checks++;
        if (state_o !== 2'd1 || ctl !== C_NORM) begin
            errors++;
            $display("FAIL hold_return got st=%0d %b want 1 %b", state_o, ctl, C_NORM);
        end
        cyc();
        checks++;
        if (state_o !== 2'd0 || flush_count !== 1) begin
            errors++;
            $display("FAIL hold_run got st=%0d f=%0d want 0/1", state_o, flush_count);
        end
    endtask

    task automatic test_imem;
        imem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (ctl !== C_IMEM) begin
                errors++;
                $display("FAIL imem%0d got %b want %b", i, ctl, C_IMEM);
            end
            cyc();
        end
        imem_ready = 1;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            errors++;
            $display("FAIL imem_after got %b want %b", ctl, C_NORM);
        end
    endtask

    task automatic test_reset_pending;
        dmem_busy = 1; ex_branch_taken = 1;
        cyc();
        ex_branch_taken = 0;
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL rp_state got %0d want 2", state_o);
        end
        rst = 1;
        #2;
        checks++;
        if (state_o !== 2'd0 || stall_cycles !== 0 || flush_count !== 0 || ctl !== C_RST) begin
            errors++;
            $display("FAIL rp_async got st=%0d s=%0d f=%0d %b want 0/0/0 %b",
                     state_o, stall_cycles, flush_count, ctl, C_RST);
        end
        cyc();
        dmem_busy = 0; rst = 0;
        #2;
        checks++;
        if (ctl !== C_NORM) begin
            errors++;
            $display("FAIL rp_release got %b want %b", ctl, C_NORM);
        end
        cyc();
        checks++;
        if (flush_count !== 0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL rp_noflush got f=%0d st=%0d want 0/0", flush_count, state_o);
        end
    endtask

    task automatic test_saturate;
        imem_ready = 0;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) cyc();
        checks++;
        if (stall_cycles !== 4'hF) begin
            errors++;
            $display("FAIL saturate got %0d want 15", stall_cycles);
        end
        cnt_clear = 1;
        cyc();
        cnt_clear = 0; imem_ready = 1;
        checks++;
        if (stall_cycles !== 0) begin
            errors++;
            $display("FAIL clear_prio got %0d want 0", stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_load();
        test_dmem_branch();
        test_hold_return();
        test_imem();
        test_reset_pending();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating performance counters.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: id_opcode  input  7  opcode field of the instruction held in IF/ID.
REQ-005 Port: id_rs1, id_rs2  input  5 each  source register fields from IF/ID.
REQ-006 Port: ex_rd  input  5  destination register of the instruction in EX.
REQ-007 Port: ex_mem_read  input  1  the instruction in EX is a load.
REQ-008 Port: ex_branch_taken  input  1  a branch or jump resolved taken in EX this cycle.
REQ-009 Port: imem_ready  input  1  instruction memory returns a valid word this cycle.
REQ-010 Port: dmem_busy  input  1  data memory is still servicing an access; the whole pipeline must hold.
REQ-011 Port: cnt_clear  input  1  synchronous clear of both counters.
REQ-012 Port: pc_write, if_id_enable, if_id_flush, id_ex_bubble, pipe_hold  output  1 each  pipeline control.
REQ-013 Port: stall_cycles, flush_count  output  CNT_W each  performance counters.
REQ-014 Port: state_o  output  2  current FSM state, for debug.

Function
REQ-015 uses_rs1 SHALL be 1 for every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111; uses_rs2 SHALL be 1 only for opcodes 0110011, 0100011 and 1100011.
REQ-016 load_use SHALL be ex_mem_read and ex_rd!=0 and ((uses_rs1 and ex_rd==id_rs1) or (uses_rs2 and ex_rd==id_rs2)).
REQ-017 FSM states SHALL be RUN=0, HOLD=1 and FLUSH_PEND=2; control outputs SHALL be combinational from state and current inputs.
REQ-018 In RUN, the following priority SHALL apply: dmem_busy > ex_branch_taken > load_use > !imem_ready > normal.
REQ-019 RUN + dmem_busy: pipe_hold=1, pc_write=0, if_id_enable=0, if_id_flush=0, id_ex_bubble=0; next state SHALL be FLUSH_PEND if ex_branch_taken, else HOLD.
REQ-020 RUN + ex_branch_taken: pc_write=1, if_id_enable=1, if_id_flush=1, id_ex_bubble=1; the state stays RUN and flush_count increments.
REQ-021 RUN + load_use: pc_write=0, if_id_enable=0, id_ex_bubble=1, if_id_flush=0; stall_cycles increments (one-cycle stall, since the bubble clears ex_mem_read).
REQ-022 RUN + !imem_ready: pc_write=0, if_id_enable=1, if_id_flush=1 (NOP into IF/ID), id_ex_bubble=0; stall_cycles increments.
REQ-023 RUN normal: pc_write=1, if_id_enable=1, if_id_flush=0, id_ex_bubble=0, pipe_hold=0.
REQ-024 HOLD: outputs SHALL be as in REQ-019 while dmem_busy=1; an ex_branch_taken seen during HOLD SHALL move the state to FLUSH_PEND; when dmem_busy=0 and no branch is latched, the state SHALL return to RUN and the RUN outputs SHALL apply in that same cycle.
REQ-025 FLUSH_PEND: the hold outputs SHALL apply while dmem_busy=1; in the first cycle with dmem_busy=0, the REQ-020 outputs SHALL be driven regardless of ex_branch_taken, flush_count SHALL increment, and the next state SHALL be RUN.
REQ-026 stall_cycles SHALL increment in every cycle in which pipe_hold=1 or a REQ-021/REQ-022 stall applies.
REQ-027 Counters SHALL saturate at all-ones; cnt_clear SHALL take priority over increment.
REQ-028 Encoding 3 of state_o SHALL be unreachable; if it is ever entered, the next state SHALL be RUN.

Reset
REQ-029 While rst=1, independent of clk: state=RUN, counters=0, pc_write=0, if_id_enable=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
REQ-030 Reset asserted mid-HOLD or mid-FLUSH_PEND SHALL discard any pending flush.

Structure
REQ-031 Opcode constants and the FSM state encoding SHALL live in the shared pipeline package.
REQ-032 The counter SHALL be a sub-module sat_counter (parameters CNT_W; inputs inc and clr), instantiated twice.

Verification
REQ-033 id ADD x5,x6,x7 with ex_mem_read=1, ex_rd=6 -> one cycle with pc_write=0, if_id_enable=0, id_ex_bubble=1; stall_cycles=1.
REQ-034 id LUI x5 with ex_mem_read=1, ex_rd=0 or with a matching rs1 field -> no stall; outputs at normal values.
REQ-035 ex_branch_taken=1 together with load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1; stall_cycles unchanged.
REQ-036 dmem_busy for 3 cycles with ex_branch_taken pulsed in cycle 1 -> pipe_hold=1 for 3 cycles, then a single flush cycle; flush_count=1; stall_cycles=3.
REQ-037 imem_ready=0 for 2 cycles -> if_id_flush=1 and pc_write=0 on both cycles, then normal outputs.
REQ-038 Assert rst during FLUSH_PEND, release with dmem_busy=0 -> state RUN, no flush, counters 0; 2^CNT_W+5 stalls -> counter holds all-ones.
